// File: rtl/debug_probe_pager_pkg.sv
// Shared types and page-index helpers for the debug probe pager.
package debug_pkg;

    typedef enum logic {ST_LIVE, ST_FROZEN} probe_state_t;

    // Next page index, wrapping from cnt-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned cnt);
        return (idx + 32'd1 >= cnt) ? 32'd0 : idx + 32'd1;
    endfunction

    // Previous page index, wrapping from 0 to cnt-1.
    function automatic int unsigned wrap_dec(input int unsigned idx, input int unsigned cnt);
        return (idx == 32'd0) ? cnt - 32'd1 : idx - 32'd1;
    endfunction

endpackage

// File: rtl/debug_probe_pager_if.sv
// Probe inputs, paging controls and display outputs of the debug probe pager.
interface debug_probe_pager_if #(
    parameter int unsigned CHANNEL_CNT = 8,
    parameter int unsigned DATA_WIDTH  = 32
);
    localparam int unsigned LOG2_CH = $clog2(CHANNEL_CNT > 1 ? CHANNEL_CNT : 2);

    logic [CHANNEL_CNT*DATA_WIDTH-1:0] probe_data;
    logic                              page_next;
    logic                              page_prev;
    logic                              auto_mode;
    logic                              freeze_btn;
    logic [DATA_WIDTH-1:0]             number_o;
    logic [LOG2_CH-1:0]                page_o;
    logic                              frozen_o;
    logic                              page_change_o;

    modport master (
        output probe_data, page_next, page_prev, auto_mode, freeze_btn,
        input  number_o, page_o, frozen_o, page_change_o
    );

    modport slave (
        input  probe_data, page_next, page_prev, auto_mode, freeze_btn,
        output number_o, page_o, frozen_o, page_change_o
    );

endinterface

// File: rtl/debug_probe_pager_rise_edge_detect.sv
// Rising-edge detector; history resets high so a level held through reset gives no edge.
module rise_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic edge_o
);
    logic hist_q;
    logic hist_d;

    // History follows the input every cycle.
    always_comb begin
        hist_d = in;
    end

    // History register, forced high in reset.
    always_ff @(posedge clock) begin
        if (reset) hist_q <= 1'b1;
        else       hist_q <= hist_d;
    end

    assign edge_o = in & ~hist_q;

endmodule

// File: rtl/debug_probe_pager.sv
// Pages CHANNEL_CNT probe words onto one registered display word, with auto-cycle and freeze.
module debug_probe_pager
    import debug_pkg::*;
#(
    parameter int unsigned CHANNEL_CNT = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned AUTO_PERIOD = 50_000_000
) (
    input  logic               clock,
    input  logic               reset,
    debug_probe_pager_if.slave bus
);
    localparam int unsigned LOG2_CH = $clog2(CHANNEL_CNT > 1 ? CHANNEL_CNT : 2);
    localparam int unsigned CNT_W   = $clog2(AUTO_PERIOD);
    localparam int unsigned BUS_W   = CHANNEL_CNT * DATA_WIDTH;

    logic next_edge;
    logic prev_edge;
    logic freeze_edge;

    rise_edge_detect u_next   (.clock(clock), .reset(reset), .in(bus.page_next),  .edge_o(next_edge));
    rise_edge_detect u_prev   (.clock(clock), .reset(reset), .in(bus.page_prev),  .edge_o(prev_edge));
    rise_edge_detect u_freeze (.clock(clock), .reset(reset), .in(bus.freeze_btn), .edge_o(freeze_edge));

    probe_state_t          state_q, state_d;
    logic [LOG2_CH-1:0]    page_q, page_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BUS_W-1:0]      snap_q, snap_d;
    logic [DATA_WIDTH-1:0] number_q, number_d;
    logic                  page_change_q, page_change_d;
    logic                  auto_hit;
    logic [BUS_W-1:0]      src;

    // Page selection, auto counter, freeze FSM and displayed-word selection.
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        number_d = '0;
        auto_hit = bus.auto_mode && (cnt_q == CNT_W'(AUTO_PERIOD - 1));

        // Simultaneous next+prev cancel; manual edges pre-empt an auto advance.
        if (next_edge && !prev_edge) begin
            page_d = LOG2_CH'(wrap_inc(32'(page_q), CHANNEL_CNT));
        end else if (prev_edge && !next_edge) begin
            page_d = LOG2_CH'(wrap_dec(32'(page_q), CHANNEL_CNT));
        end else if (!next_edge && !prev_edge && auto_hit) begin
            page_d = LOG2_CH'(wrap_inc(32'(page_q), CHANNEL_CNT));
        end

        if (!bus.auto_mode || next_edge || prev_edge || auto_hit) cnt_d = '0;
        else                                                      cnt_d = cnt_q + CNT_W'(1);

        if (freeze_edge) begin
            if (state_q == ST_LIVE) begin
                state_d = ST_FROZEN;
                snap_d  = bus.probe_data;
            end else begin
                state_d = ST_LIVE;
            end
        end

        // Use next-cycle page and state so number_o and page_o always agree.
        src = (state_d == ST_FROZEN) ? snap_d : bus.probe_data;
        for (int k = 0; k < CHANNEL_CNT; k++) begin
            if (page_d == LOG2_CH'(k)) number_d = src[k*DATA_WIDTH +: DATA_WIDTH];
        end

        page_change_d = (page_d != page_q);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_LIVE;
            page_q        <= '0;
            cnt_q         <= '0;
            snap_q        <= '0;
            number_q      <= '0;
            page_change_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            page_q        <= page_d;
            cnt_q         <= cnt_d;
            snap_q        <= snap_d;
            number_q      <= number_d;
            page_change_q <= page_change_d;
        end
    end

    assign bus.number_o      = number_q;
    assign bus.page_o        = page_q;
    assign bus.frozen_o      = (state_q == ST_FROZEN);
    assign bus.page_change_o = page_change_q;

endmodule

// File: tb/tb_debug_probe_pager.sv
// Scoreboard bench for debug_probe_pager against a cycle-level behavioural model.
module tb_debug_probe_pager;
    localparam int unsigned C  = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned P  = 4;

    typedef struct {
        logic [DW-1:0] num;
        int            page;
        bit            frz;
        bit            pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    debug_probe_pager_if #(.CHANNEL_CNT(C), .DATA_WIDTH(DW)) bus ();

    debug_probe_pager #(.CHANNEL_CNT(C), .DATA_WIDTH(DW), .AUTO_PERIOD(P)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;

    // Reference model state.
    logic [DW-1:0] probe_m [C];
    logic [DW-1:0] snap_m  [C];
    int            m_page, m_cnt;
    bit            m_frozen, m_pn, m_pp, m_pf;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a registered result; compare against the queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("number_o",      bus.number_o,             e.num);
                chk("page_o",        DW'(bus.page_o),          DW'(e.page));
                chk("frozen_o",      DW'(bus.frozen_o),        DW'(e.frz));
                chk("page_change_o", DW'(bus.page_change_o),   DW'(e.pc));
            end
        end
    end

    // Apply one cycle of inputs and push the model's expected post-edge outputs.
    task automatic step(input bit r, input bit nx, input bit pv, input bit am, input bit fz);
        exp_t e;
        bit   ne, pe, fe;
        int   old;
        @(negedge clk);
        rst            = r;
        bus.page_next  = nx;
        bus.page_prev  = pv;
        bus.auto_mode  = am;
        bus.freeze_btn = fz;
        for (int k = 0; k < C; k++) bus.probe_data[k*DW +: DW] = probe_m[k];
        if (r) begin
            m_page = 0; m_cnt = 0; m_frozen = 0;
            for (int k = 0; k < C; k++) snap_m[k] = '0;
            m_pn = 1; m_pp = 1; m_pf = 1;
            e.num = '0; e.page = 0; e.frz = 0; e.pc = 0;
        end else begin
            ne  = nx && !m_pn;
            pe  = pv && !m_pp;
            fe  = fz && !m_pf;
            old = m_page;
            if (ne && pe)                   m_page = m_page;
            else if (ne)                    m_page = (m_page + 1) % C;
            else if (pe)                    m_page = (m_page + C - 1) % C;
            else if (am && m_cnt == P - 1)  m_page = (m_page + 1) % C;
            if (!am || ne || pe || m_cnt == P - 1) m_cnt = 0;
            else                                   m_cnt = m_cnt + 1;
            if (fe) begin
                if (!m_frozen) begin
                    for (int k = 0; k < C; k++) snap_m[k] = probe_m[k];
                    m_frozen = 1;
                end else begin
                    m_frozen = 0;
                end
            end
            m_pn = nx; m_pp = pv; m_pf = fz;
            e.num  = m_frozen ? snap_m[m_page] : probe_m[m_page];
            e.page = m_page;
            e.frz  = m_frozen;
            e.pc   = (m_page != old);
        end
        sb.push_back(e);
    endtask

    // Press-and-release of next (two cycles).
    task automatic pulse_next(input bit am);
        step(0, 1, 0, am, 0);
        step(0, 0, 0, am, 0);
    endtask

    initial begin
        for (int k = 0; k < C; k++) probe_m[k] = 32'hA000_0000 | DW'(k);
        bus.page_next = 0; bus.page_prev = 0; bus.auto_mode = 0; bus.freeze_btn = 0;
        bus.probe_data = '0;

        // Reset, next held through release: no edge.
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Eight next pulses wrap back to page 0, then prev wraps to 7.
        for (int i = 0; i < 8; i++) pulse_next(0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Auto mode, with a manual next mid-period.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Simultaneous next and prev.
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Freeze scenario from a clean reset.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) pulse_next(0);
        probe_m[3] = 32'h0000_1234;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        probe_m[3] = 32'h0000_FFFF;
        probe_m[4] = 32'h5555_0004;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        pulse_next(0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0);

        // Reset mid-auto while frozen.
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit am;
            am = ((i / 40) % 2) == 1;
            if ($urandom_range(0, 4) == 0) probe_m[$urandom_range(0, C-1)] = $urandom;
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 am,
                 $urandom_range(0, 9) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", DW'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
